spi_result_transmitter: RTL and testbench
=========================================

Name: spi_result_transmitter

Overview:
- SPI peripheral-side transmitter that drives CIPO back to the SPI host. It is the return path for the existing COPI receive path.
- Shifts out result/status bytes supplied by the controller FSM. Shares SCLK and spi_cs_n with the receive path.
- SPI mode 0: MSB first. The peripheral changes CIPO on SCLK falling edges and the host samples on rising edges.
- All logic runs in the clk domain. SCLK and spi_cs_n are oversampled through synchronizers.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on SCLK and spi_cs_n (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when no data is queued (underrun filler).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock from host; asynchronous to clk.
- spi_cs_n  input  1  SPI chip select from host, active low; asynchronous to clk.
- CIPO  output  1  serial data to host.
- cipo_oe  output  1  output enable for the CIPO pad; high only while CS is asserted (synced).
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty; a byte is accepted when tx_valid && tx_ready.
- byte_sent  output  1  one-clk pulse when the 8th bit of a byte has been sampled by the host.
- underrun  output  1  one-clk pulse when IDLE_BYTE is loaded because the holding register is empty.
- aborted  output  1  one-clk pulse when CS deasserts with 1..7 bits of a byte transferred.

Behaviour:
- Reset values (asynchronous, immediate):
  - CIPO=0, cipo_oe=0, tx_ready=1.
  - byte_sent=0, underrun=0, aborted=0.
  - Holding register empty; shift register 0; bit_cnt=0; FSM in IDLE.
  - Synchronizer flops reset: SCLK to 0, CS to 1.
- Synchronization and edges:
  - SCLK and spi_cs_n each pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one extra registered copy.
  - Edge-to-action latency: SYNC_STAGES+1 clk cycles.
  - Valid operation requires each SCLK high and low phase to be at least SYNC_STAGES+3 clk cycles.
- Holding register (1 entry):
  - tx_ready = !hold_full.
  - On the accept cycle, hold_full sets at the next edge and tx_ready drops.
  - A pop from the shift path clears hold_full. tx_ready rises the cycle after the pop.
  - Push and pop cannot coincide, because a push requires empty and a pop requires full.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: cipo_oe=0, CIPO=0. A synced CS falling edge moves to LOAD.
  - LOAD (1 cycle):
    - If hold_full, shift<=hold and pop the holding register.
    - Otherwise, shift<=IDLE_BYTE and pulse underrun.
    - bit_cnt<=0, cipo_oe<=1, CIPO<=bit 7 of the loaded byte. Then go to SHIFT.
  - SHIFT, synced SCLK rising edge: bit_cnt<=bit_cnt+1.
    - When bit_cnt becomes 8, pulse byte_sent and set a reload flag.
  - SHIFT, synced SCLK falling edge:
    - If the reload flag is set, clear it and do the LOAD action in place (back-to-back bytes with no gap; pop or underrun applies), with bit_cnt<=0.
    - Otherwise, shift the register left by 1 and drive CIPO with the new bit 7.
  - SHIFT, synced CS rising edge (highest priority over SCLK edges in the same cycle):
    - Go to IDLE; cipo_oe<=0, CIPO<=0.
    - If 1<=bit_cnt<=7, pulse aborted; the partial byte is discarded and not retried.
    - If bit_cnt is 0 or 8, no aborted pulse. A byte already loaded but with 0 bits clocked is discarded silently.
    - The holding register keeps its content.
- bit_cnt is 4 bits wide and counts 0..8, then returns to 0 on reload. It never wraps past 8.
- byte_sent, underrun and aborted each last exactly 1 clk.
- Reset mid-transfer: everything returns to reset values immediately. A partially shifted byte is lost, with no pulses.
- A CS falling edge while in LOAD is impossible by construction. Glitches shorter than SYNC_STAGES clk cycles are not guaranteed to be filtered.

Test Plan:
- Push 0xA5, then CS low and 8 SCLK cycles:
  - Host samples 1,0,1,0,0,1,0,1.
  - One byte_sent pulse; tx_ready=1 afterwards; no underrun.
- Push 0x3C, start CS, push 0xC3 during bit 3, then 16 SCLK cycles:
  - Host reads 0x3C then 0xC3 with no gap.
  - Two byte_sent pulses; tx_ready low from the 0xC3 accept until the reload pop.
- CS low with the holding register empty, 8 SCLK cycles:
  - Host reads 0xFF; one underrun pulse at LOAD; one byte_sent pulse.
- Push 0xF0, CS low, 3 SCLK cycles, then CS high:
  - aborted pulses once; cipo_oe=0.
  - Next transaction with a new push of 0x81 reads 0x81.
- Push 0x55, then tx_valid held with 0xAA while full, then CS low and 16 SCLK cycles:
  - 0xAA is accepted only after 0x55 is popped.
  - Host reads 0x55 then 0xAA.
- Assert rst_n=0 after 5 bits:
  - CIPO=0, cipo_oe=0, tx_ready=1 immediately; no byte_sent or aborted pulse.

Source files
------------

// File: rtl/spi_result_transmitter.sv
// SPI mode-0 peripheral transmitter: drives CIPO from a one-entry holding register,
// with SCLK/CS oversampled into the clk domain.
module spi_result_transmitter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       spi_cs_n,
  output logic       CIPO,
  output logic       cipo_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       byte_sent,
  output logic       underrun,
  output logic       aborted
);
  localparam int unsigned LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_SHIFT = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync;
  logic       r_sclk_d, r_cs_d;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_hold, r_shift, w_shift_nxt, w_load_byte;
  logic       r_hold_full;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_reload, w_reload_nxt;
  logic       r_cipo, w_cipo_nxt, r_oe, w_oe_nxt;
  logic       r_byte_sent, w_byte_sent_nxt;
  logic       r_underrun, w_underrun_nxt;
  logic       r_aborted, w_aborted_nxt;
  logic       w_pop, w_do_load;
  logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_d    <= r_sclk_sync[LAST];
      r_cs_d      <= r_cs_sync[LAST];
    end
  end

  assign w_sclk_rise = r_sclk_sync[LAST] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_sync[LAST] & r_sclk_d;
  assign w_cs_fall   = ~r_cs_sync[LAST] & r_cs_d;
  assign w_cs_rise   = r_cs_sync[LAST] & ~r_cs_d;

  // Push and pop are mutually exclusive: push needs empty, pop needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
    end else if (tx_valid && !r_hold_full) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end else if (w_pop) begin
      r_hold_full <= 1'b0;
    end else begin
      r_hold_full <= r_hold_full;
    end
  end

  assign w_load_byte = r_hold_full ? r_hold : IDLE_BYTE;

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_reload_nxt    = r_reload;
    w_cipo_nxt      = r_cipo;
    w_oe_nxt        = r_oe;
    w_byte_sent_nxt = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_aborted_nxt   = 1'b0;
    w_pop           = 1'b0;
    w_do_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_oe_nxt   = 1'b0;
        w_cipo_nxt = 1'b0;
        if (w_cs_fall) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_do_load   = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        // CS release wins over any SCLK edge seen in the same cycle.
        if (w_cs_rise) begin
          w_state_nxt   = ST_IDLE;
          w_oe_nxt      = 1'b0;
          w_cipo_nxt    = 1'b0;
          w_reload_nxt  = 1'b0;
          w_aborted_nxt = (r_bit_cnt >= 4'd1) && (r_bit_cnt <= 4'd7);
        end else if (w_sclk_rise) begin
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_byte_sent_nxt = 1'b1;
            w_reload_nxt    = 1'b1;
          end else begin
            w_reload_nxt    = r_reload;
          end
        end else if (w_sclk_fall) begin
          if (r_reload) begin
            w_do_load = 1'b1;
          end else begin
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_cipo_nxt  = r_shift[6];
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_do_load) begin
      w_shift_nxt    = w_load_byte;
      w_pop          = r_hold_full;
      w_underrun_nxt = ~r_hold_full;
      w_bit_cnt_nxt  = 4'd0;
      w_reload_nxt   = 1'b0;
      w_oe_nxt       = 1'b1;
      w_cipo_nxt     = w_load_byte[7];
    end else begin
      w_pop          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 4'd0;
      r_reload    <= 1'b0;
      r_cipo      <= 1'b0;
      r_oe        <= 1'b0;
      r_byte_sent <= 1'b0;
      r_underrun  <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_reload    <= w_reload_nxt;
      r_cipo      <= w_cipo_nxt;
      r_oe        <= w_oe_nxt;
      r_byte_sent <= w_byte_sent_nxt;
      r_underrun  <= w_underrun_nxt;
      r_aborted   <= w_aborted_nxt;
    end
  end

  assign CIPO      = r_cipo;
  assign cipo_oe   = r_oe;
  assign tx_ready  = ~r_hold_full;
  assign byte_sent = r_byte_sent;
  assign underrun  = r_underrun;
  assign aborted   = r_aborted;
endmodule

// File: tb/tb_spi_result_transmitter.sv
// Self-checking bench for spi_result_transmitter: a host model clocks SPI mode 0,
// read bytes are compared against a scoreboard of pushed/expected bytes.
module tb_spi_result_transmitter;
  localparam int HALF = 8;

  logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       cipo, oe, tx_ready, byte_sent, underrun, aborted;

  int n_checks = 0, n_errors = 0;
  int c_sent = 0, c_under = 0, c_abort = 0;
  int b_sent, b_under, b_abort;
  logic [7:0] sb[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_acc;
  int rx_n;

  typedef struct {
    logic       push;
    logic [7:0] data;
    int         nbits;
    int         exp_sent;
    int         exp_under;
    int         exp_abort;
  } vec_t;
  vec_t vecs[6];

  spi_result_transmitter #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .spi_cs_n(cs_n), .CIPO(cipo),
    .cipo_oe(oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .byte_sent(byte_sent), .underrun(underrun), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // A pulse lasting more than one clk is counted more than once.
  always @(posedge clk) begin
    if (byte_sent) c_sent <= c_sent + 1;
    if (underrun)  c_under <= c_under + 1;
    if (aborted)   c_abort <= c_abort + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_sent = c_sent; b_under = c_under; b_abort = c_abort;
  endtask

  task automatic chk_pulses(input int s, input int u, input int a);
    chk("byte_sent_pulses", c_sent - b_sent, s);
    chk("underrun_pulses", c_under - b_under, u);
    chk("aborted_pulses", c_abort - b_abort, a);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit track);
    int w = 0;
    while (!tx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) chk("push_ready_timeout", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (track) sb.push_back(d);
  endtask

  task automatic sclk_bit(input bit last);
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    rx_acc = {rx_acc[6:0], cipo};
    rx_n++;
    if (rx_n == 8) begin
      rx_q.push_back(rx_acc);
      rx_n = 0;
    end
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    if (last) cs_n = 1'b1;
  endtask

  task automatic host_xfer(input int nbits, input int push_at, input logic [7:0] pdata);
    rx_n = 0; rx_acc = 8'h00;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == push_at) begin
        tx_data = pdata; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        sb.push_back(pdata);
        chk("ready_low_after_accept", tx_ready, 0);
      end
      sclk_bit(i == nbits - 1);
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic drain();
    logic [7:0] e;
    while (rx_q.size() > 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rx_byte", rx_q.pop_front(), -1);
      end else begin
        e = sb.pop_front();
        chk("rx_byte", rx_q.pop_front(), e);
      end
    end
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] e;
    int w;
    logic acc_oe;
    vecs[0] = '{1'b1, 8'hA5, 8, 1, 0, 0};
    vecs[1] = '{1'b0, 8'h00, 8, 1, 1, 0};
    vecs[2] = '{1'b1, 8'hF0, 3, 0, 0, 1};
    vecs[3] = '{1'b1, 8'h81, 8, 1, 0, 0};
    vecs[4] = '{1'b1, 8'h5A, 1, 0, 0, 1};
    vecs[5] = '{1'b1, 8'h3C, 7, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_cipo", cipo, 0);
    chk("reset_oe", oe, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_pulses", byte_sent | underrun | aborted, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      snap();
      if (vecs[k].push) push_byte(vecs[k].data, 1'b1);
      else sb.push_back(8'hFF);
      host_xfer(vecs[k].nbits, -1, 8'h00);
      chk_pulses(vecs[k].exp_sent, vecs[k].exp_under, vecs[k].exp_abort);
      if (vecs[k].nbits < 8) begin
        e = sb.pop_front();
        chk("partial_bits", rx_acc, e >> (8 - vecs[k].nbits));
      end
      drain();
      chk("oe_after_xfer", oe, 0);
      chk("ready_after_xfer", tx_ready, 1);
    end

    // back-to-back bytes, second pushed mid-transfer
    snap();
    push_byte(8'h3C, 1'b1);
    host_xfer(16, 3, 8'hC3);
    chk_pulses(2, 0, 0);
    drain();
    chk("ready_after_b2b", tx_ready, 1);

    // tx_valid held while the holding register is full
    snap();
    push_byte(8'h55, 1'b1);
    acc_oe = 1'b0;
    fork
      begin
        tx_data = 8'hAA; tx_valid = 1'b1;
        w = 0;
        while (!tx_ready && w < 2000) begin
          @(negedge clk);
          w++;
        end
        acc_oe = oe;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("held_valid_accepted", tx_ready, 0);
        sb.push_back(8'hAA);
      end
      begin
        repeat (20) @(negedge clk);
        host_xfer(16, -1, 8'h00);
      end
    join
    chk("accept_after_pop", acc_oe, 1);
    chk_pulses(2, 0, 0);
    drain();

    // reset mid-transfer
    push_byte(8'h9D, 1'b0);
    snap();
    rx_n = 0; rx_acc = 8'h00;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    push_byte(8'h77, 1'b0);
    for (int i = 0; i < 5; i++) sclk_bit(1'b0);
    repeat (4) @(negedge clk);
    chk("pre_reset_cipo", cipo, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_cipo", cipo, 0);
    chk("midreset_oe", oe, 0);
    chk("midreset_tx_ready", tx_ready, 1);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset_sent", c_sent - b_sent, 0);
    chk("midreset_aborted", c_abort - b_abort, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    snap();
    push_byte(8'h42, 1'b1);
    host_xfer(8, -1, 8'h00);
    chk_pulses(1, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
